wide_to_narrow_conv: RTL and testbench

Parametrised wide-to-narrow bus width converter: accepts one wide word per valid/ready handshake and emits it as 1..2^RATIO_LOG narrow beats on a valid/ready output port. It is the successor of the fixed-burst high-to-low splitter in the bus-decode path. It adds:
- back-pressure on both sides;
- per-word partial beat count;
- selectable slice order;
- zero-bubble back-to-back word transfer.

---
 rtl/bus_conv_pkg.sv | 18 +
 rtl/bus_slice_sel.sv | 23 ++
 rtl/wide_to_narrow_conv.sv | 78 +++++++
 tb/tb_wide_to_narrow_conv.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_conv_pkg.sv
// Shared types and helpers for the bus width converters.
package bus_conv_pkg;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  // Maps a beat number onto the physical slice position of the wide word.
  function automatic int slice_idx(
    input int cnt,
    input int last,
    input bit msb_first
  );
    return msb_first ? (last - cnt) : cnt;
  endfunction

endpackage

// File: rtl/bus_slice_sel.sv
// Combinational wide-to-narrow slice selector.
module bus_slice_sel
  import bus_conv_pkg::*;
#(
  parameter int NARROW_WIDTH = 32,
  parameter int RATIO_LOG    = 2
) (
  input  logic [NARROW_WIDTH*(2**RATIO_LOG)-1:0] data,
  input  logic [RATIO_LOG-1:0]                   idx,
  input  logic                                   msb_first,
  output logic [NARROW_WIDTH-1:0]                slice
);

  localparam int NB = 2 ** RATIO_LOG;

  logic [RATIO_LOG-1:0] sel;

  always_comb begin
    sel   = RATIO_LOG'(slice_idx(32'(idx), NB - 1, msb_first));
    slice = data[sel*NARROW_WIDTH +: NARROW_WIDTH];
  end

endmodule

// File: rtl/wide_to_narrow_conv.sv
// Wide-to-narrow bus converter with per-word beat count.
// Optional out_last port enabled by defining W2N_LAST_EN.
module wide_to_narrow_conv
  import bus_conv_pkg::*;
#(
  parameter int NARROW_WIDTH = 32,
  parameter int RATIO_LOG    = 2,
  parameter bit MSB_FIRST    = 1'b0
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NARROW_WIDTH*(2**RATIO_LOG)-1:0] in_data,
  input  logic [RATIO_LOG-1:0]                   in_beats_m1,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [NARROW_WIDTH-1:0]                out_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   busy
`ifdef W2N_LAST_EN
  ,
  output logic                                   out_last
`endif
);

  localparam int W = NARROW_WIDTH * (2 ** RATIO_LOG);

  state_t               state;
  logic [RATIO_LOG-1:0] cnt;
  logic [RATIO_LOG-1:0] hold_m1;
  logic [W-1:0]         hold_data;
  logic                 last_beat;
  logic                 in_fire;
  logic                 out_fire;

  assign out_valid = (state == SEND);
  assign busy      = out_valid;
  assign last_beat = (cnt == hold_m1);
  assign out_fire  = out_valid & out_ready;
  // Ready on the last beat lets the next word reload with no bubble.
  assign in_ready  = (state == IDLE) | (out_fire & last_beat);
  assign in_fire   = in_valid & in_ready;

`ifdef W2N_LAST_EN
  assign out_last = out_valid & last_beat;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      hold_m1   <= '0;
      hold_data <= '0;
    end else if (in_fire) begin
      state     <= SEND;
      cnt       <= '0;
      hold_m1   <= in_beats_m1;
      hold_data <= in_data;
    end else if (out_fire) begin
      if (last_beat) begin
        state <= IDLE;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  bus_slice_sel #(
    .NARROW_WIDTH(NARROW_WIDTH),
    .RATIO_LOG   (RATIO_LOG)
  ) u_sel (
    .data     (hold_data),
    .idx      (cnt),
    .msb_first(MSB_FIRST),
    .slice    (out_data)
  );

endmodule

// File: tb/tb_wide_to_narrow_conv.sv
// Randomized bench for wide_to_narrow_conv with a beat-queue model.
module tb_wide_to_narrow_conv;

  localparam int NW = 32;
  localparam int RL = 2;
  localparam int NB = 4;
  localparam int W  = NW * NB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  in_data;
  logic [RL-1:0] in_beats_m1;
  logic          in_valid;
  logic          out_ready;
  logic          rdy0, rdy1, vld0, vld1, busy0, busy1;
  logic [NW-1:0] dat0, dat1;
`ifdef W2N_LAST_EN
  logic          last0, last1;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit rr_en = 1'b0;

  logic [NW-1:0] q0[$];
  logic [NW-1:0] q1[$];
  logic [NW-1:0] got0[$];
  logic [NW-1:0] got1[$];

  logic [W-1:0] word_a = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
  logic [NW-1:0] lit[4] = '{32'h1111_1111, 32'h2222_2222,
                            32'h3333_3333, 32'h4444_4444};

  always #5 clk = ~clk;

  wide_to_narrow_conv #(.NARROW_WIDTH(NW), .RATIO_LOG(RL), .MSB_FIRST(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_beats_m1(in_beats_m1),
    .in_valid(in_valid), .in_ready(rdy0), .out_data(dat0), .out_valid(vld0),
    .out_ready(out_ready), .busy(busy0)
`ifdef W2N_LAST_EN
    , .out_last(last0)
`endif
  );

  wide_to_narrow_conv #(.NARROW_WIDTH(NW), .RATIO_LOG(RL), .MSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_beats_m1(in_beats_m1),
    .in_valid(in_valid), .in_ready(rdy1), .out_data(dat1), .out_valid(vld1),
    .out_ready(out_ready), .busy(busy1)
`ifdef W2N_LAST_EN
    , .out_last(last1)
`endif
  );

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each DUT is a queue of beats still owed for the current word.
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      chk("rst_valid", {vld0, vld1}, 2'b00);
      chk("rst_ready", {rdy0, rdy1}, 2'b11);
      chk("rst_busy", {busy0, busy1}, 2'b00);
      chk("rst_data", {dat0, dat1}, '0);
`ifdef W2N_LAST_EN
      chk("rst_last", {last0, last1}, 2'b00);
`endif
    end else begin
      automatic int  n = q0.size();
      automatic bit  erdy = (n == 0) || (out_ready && n == 1);
      chk("valid0", vld0, n != 0);
      chk("valid1", vld1, q1.size() != 0);
      chk("busy", {busy0, busy1}, {2{n != 0}});
      chk("in_ready", {rdy0, rdy1}, {2{erdy}});
      if (n != 0) begin
        chk("data0", dat0, q0[0]);
        chk("data1", dat1, q1[0]);
      end
`ifdef W2N_LAST_EN
      chk("last", {last0, last1}, {2{n == 1}});
`endif
      if (n != 0 && out_ready) begin
        got0.push_back(dat0);
        got1.push_back(dat1);
        void'(q0.pop_front());
        void'(q1.pop_front());
      end
      if (in_valid && erdy) begin
        for (int k = 0; k <= int'(in_beats_m1); k++) begin
          q0.push_back(in_data[k*NW +: NW]);
          q1.push_back(in_data[(NB-1-k)*NW +: NW]);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rr_en) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send_word(input logic [W-1:0] d, input logic [RL-1:0] m1);
    int t;
    in_data     = d;
    in_beats_m1 = m1;
    in_valid    = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (rdy0) break;
      t++;
      if (t > 2000) begin
        chk("send_timeout", 1'b1, 1'b0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    in_data     = {$urandom, $urandom, $urandom, $urandom};
    in_beats_m1 = RL'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (q0.size() != 0 || vld0) begin
      @(posedge clk);
      #1;
      t++;
      if (t > 2000) begin
        chk("idle_timeout", 1'b1, 1'b0);
        break;
      end
    end
  endtask

  task automatic chk_got(input string name, input int n, input bit rev);
    chk({name, "_n"}, got0.size(), n);
    if (got0.size() == n && got1.size() == n)
      for (int i = 0; i < n; i++) begin
        chk({name, "_lsb"}, got0[i], lit[i % NB]);
        if (!rev) chk({name, "_msb"}, got1[i], lit[NB-1-(i % NB)]);
      end
    got0.delete();
    got1.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_beats_m1 = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Full word, both orders
    send_word(word_a, 2'd3);
    wait_idle();
    chk_got("full", 4, 1'b0);

    // Two-beat word
    send_word(word_a, 2'd1);
    wait_idle();
    chk("short_n", got0.size(), 2);
    if (got0.size() == 2) begin
      chk("short_b0", got0[0], 32'h1111_1111);
      chk("short_b1", got0[1], 32'h2222_2222);
      chk("short_m0", got1[0], 32'h4444_4444);
    end
    got0.delete();
    got1.delete();

    // Back-to-back words
    send_word(word_a, 2'd3);
    send_word(word_a, 2'd3);
    wait_idle();
    chk_got("b2b", 8, 1'b0);

    // Stall on beat 1
    send_word(word_a, 2'd3);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle();
    chk_got("stall", 4, 1'b0);

    // Reset mid-word
    send_word(word_a, 2'd3);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", vld0, 1'b0);
    chk("arst_busy", busy0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    got0.delete();
    got1.delete();
    chk("post_rst_ready", rdy0, 1'b1);
    send_word(word_a, 2'd3);
    wait_idle();
    chk_got("post_rst", 4, 1'b0);

    // Random traffic
    rr_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send_word({$urandom, $urandom, $urandom, $urandom}, RL'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    rr_en = 1'b0;
    #1 out_ready = 1'b1;
    wait_idle();
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
